neuron_layer_trainer: RTL and testbench

Sequencer that drives one `neuron_learn`-style layer through forward and learn passes over a streamed sample set for a programmable number of epochs. It accepts samples over a ready/valid handshake and generates the layer's `valid`/`learn` strobes. It holds inputs and targets stable while the layer settles, then captures the layer output and reports per-sample and per-epoch absolute error. It sits between the training-data source and a layer instance; `expected_in` back-propagation chaining is outside this block.

---
 rtl/neuron_layer_trainer.sv | 172 +++++++++++++++++
 tb/tb_neuron_layer_trainer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_trainer.sv
// neuron_layer_trainer
//   Sequences one neuron layer through forward (and optionally learn) passes
//   over a streamed sample set for a programmable number of epochs. Each
//   accepted sample is held on layer_in/layer_expected_out while the layer
//   settles. The layer output is then captured and its absolute error against
//   the target is reported per sample and accumulated per epoch.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start/train/epochs_cfg  run control; train and epochs_cfg latched at start
//   sample_valid/ready/last, sample_in, sample_expected   sample stream
//   layer_valid/learn, layer_in, layer_expected_out       drive to the layer
//   layer_out           layer outputs
//   result_valid, result_out, sample_err                  per-sample result
//   epoch_err, epoch_count                                epoch progress
//   busy, done          status; done is a one-cycle end-of-run strobe
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | sample_ready high, waiting for a sample
// FWD      | layer_valid held while the layer settles
// CAPTURE  | result_valid strobe, epoch error accumulated
// LEARN    | one-cycle learn strobe (train runs only)
// DONE     | one-cycle done strobe
module neuron_layer_trainer #(
  parameter int N      = 16,
  parameter int M      = 36,
  parameter int ZW     = 8,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              train,
  input  logic [7:0]        epochs_cfg,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              sample_last,
  input  logic [N*ZW-1:0]   sample_in,
  input  logic [M*ZW-1:0]   sample_expected,
  output logic              layer_valid,
  output logic              layer_learn,
  output logic [N*ZW-1:0]   layer_in,
  output logic [M*ZW-1:0]   layer_expected_out,
  input  logic [M*ZW-1:0]   layer_out,
  output logic              result_valid,
  output logic [M*ZW-1:0]   result_out,
  output logic [ZW+5:0]     sample_err,
  output logic [ERR_W-1:0]  epoch_err,
  output logic [7:0]        epoch_count,
  output logic              busy,
  output logic              done
);

  localparam int SW  = ZW + 6;
  localparam int EW1 = ERR_W + 1;
  localparam int CW  = $clog2(SETTLE + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_FWD     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_LEARN   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] settle_cnt;
  logic          train_q;
  logic          last_q;
  logic [7:0]    epochs_q;
  logic [SW-1:0] err_comb;
  logic [EW1-1:0] ep_sum;
  logic [7:0]    next_count;
  logic          final_epoch;
  logic          decide;

  assign sample_ready = (state == S_FETCH);
  assign layer_valid  = (state == S_FWD) || (state == S_LEARN);
  assign layer_learn  = (state == S_LEARN);
  assign result_valid = (state == S_CAPTURE);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);

  // Sum of per-element absolute differences; ZW+6 bits holds M<=64 terms.
  always_comb begin
    logic [ZW-1:0] a;
    logic [ZW-1:0] b;
    a        = '0;
    b        = '0;
    err_comb = '0;
    for (int i = 0; i < M; i++) begin
      a        = layer_out[i*ZW +: ZW];
      b        = layer_expected_out[i*ZW +: ZW];
      err_comb = err_comb + SW'((a > b) ? (a - b) : (b - a));
    end
  end

  assign ep_sum      = {1'b0, epoch_err} + EW1'(sample_err);
  assign next_count  = epoch_count + 8'd1;
  assign final_epoch = (next_count == epochs_q);
  // End-of-sample decision point: right after CAPTURE for infer, after LEARN for train.
  assign decide      = ((state == S_CAPTURE) && !train_q) || (state == S_LEARN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= S_IDLE;
      settle_cnt         <= '0;
      train_q            <= 1'b0;
      last_q             <= 1'b0;
      epochs_q           <= 8'd1;
      layer_in           <= '0;
      layer_expected_out <= '0;
      result_out         <= '0;
      sample_err         <= '0;
      epoch_err          <= '0;
      epoch_count        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            train_q     <= train;
            epochs_q    <= (epochs_cfg == 8'd0) ? 8'd1 : epochs_cfg;
            epoch_count <= '0;
            epoch_err   <= '0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (sample_valid) begin
            layer_in           <= sample_in;
            layer_expected_out <= sample_expected;
            last_q             <= sample_last;
            settle_cnt         <= CW'(SETTLE);
            state              <= S_FWD;
          end
        end
        S_FWD: begin
          settle_cnt <= settle_cnt - CW'(1);
          if (settle_cnt == CW'(1)) begin
            result_out <= layer_out;
            sample_err <= err_comb;
            state      <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          epoch_err <= ep_sum[ERR_W] ? '1 : ep_sum[ERR_W-1:0];
          if (train_q) state <= S_LEARN;
        end
        S_DONE:  state <= S_IDLE;
        default: ;
      endcase

      // Placed after the case so the epoch-boundary clear overrides the
      // accumulate performed in the same CAPTURE cycle of an infer run.
      if (decide) begin
        if (!last_q) begin
          state <= S_FETCH;
        end else begin
          epoch_count <= next_count;
          if (final_epoch) begin
            state <= S_DONE;
          end else begin
            epoch_err <= '0;
            state     <= S_FETCH;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_layer_trainer.sv
module tb_neuron_layer_trainer;
  localparam int N = 16, M = 36, ZW = 8, SETTLE = 2, ERR_W = 24;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             train = 1'b0;
  logic [7:0]       epochs_cfg = '0;
  logic             sample_valid = 1'b0;
  logic             sample_ready;
  logic             sample_last = 1'b0;
  logic [N*ZW-1:0]  sample_in = '0;
  logic [M*ZW-1:0]  sample_expected = '0;
  logic             layer_valid, layer_learn;
  logic [N*ZW-1:0]  layer_in;
  logic [M*ZW-1:0]  layer_expected_out;
  logic [M*ZW-1:0]  layer_out = '0;
  logic             result_valid;
  logic [M*ZW-1:0]  result_out;
  logic [ZW+5:0]    sample_err;
  logic [ERR_W-1:0] epoch_err;
  logic [7:0]       epoch_count;
  logic             busy, done;

  neuron_layer_trainer #(.N(N), .M(M), .ZW(ZW), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .train(train), .epochs_cfg(epochs_cfg),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_last(sample_last),
    .sample_in(sample_in), .sample_expected(sample_expected),
    .layer_valid(layer_valid), .layer_learn(layer_learn), .layer_in(layer_in),
    .layer_expected_out(layer_expected_out), .layer_out(layer_out),
    .result_valid(result_valid), .result_out(result_out), .sample_err(sample_err),
    .epoch_err(epoch_err), .epoch_count(epoch_count), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, rv_count = 0, learn_count = 0;
  always @(posedge clock) begin
    cyc++;
    if (result_valid) rv_count++;
    if (layer_learn) learn_count++;
  end

  // Reference model state: what the run should look like from the rules alone.
  int exp_acc, exp_cnt, eff_ep, last_cap;
  bit tr_lat;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int model_err(input logic [M*ZW-1:0] o, input logic [M*ZW-1:0] e);
    int s, a, b;
    s = 0;
    for (int i = 0; i < M; i++) begin
      a = int'(o[i*ZW +: ZW]);
      b = int'(e[i*ZW +: ZW]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  function automatic logic [M*ZW-1:0] rand_m();
    logic [M*ZW-1:0] v;
    for (int i = 0; i < M; i++) v[i*ZW +: ZW] = ZW'($urandom);
    return v;
  endfunction

  function automatic logic [N*ZW-1:0] rand_n();
    logic [N*ZW-1:0] v;
    for (int i = 0; i < N; i++) v[i*ZW +: ZW] = ZW'($urandom);
    return v;
  endfunction

  function automatic logic [M*ZW-1:0] fill_m(input int val);
    logic [M*ZW-1:0] v;
    for (int i = 0; i < M; i++) v[i*ZW +: ZW] = ZW'(val);
    return v;
  endfunction

  task automatic do_start(input bit tr, input logic [7:0] ep);
    start = 1'b1; train = tr; epochs_cfg = ep;
    step();
    start = 1'b0;
    tr_lat = tr; eff_ep = (ep == 8'd0) ? 1 : int'(ep); exp_cnt = 0; exp_acc = 0;
    check("start_busy", busy, 1);
    check("start_ready", sample_ready, 1);
    check("start_epoch_count", epoch_count, 0);
    check("start_epoch_err", epoch_err, 0);
  endtask

  task automatic do_sample(input bit last, input logic [N*ZW-1:0] si,
                           input logic [M*ZW-1:0] se, input logic [M*ZW-1:0] lo);
    int k, err;
    bit fin;
    k = 0;
    sample_valid = 1'b1; sample_in = si; sample_expected = se; sample_last = last; layer_out = lo;
    while (!sample_ready && k < 50) begin step(); k++; end
    if (k >= 50) begin
      check("fetch_timeout", k, 0);
      sample_valid = 1'b0;
      return;
    end
    step();
    // Scramble the source so a non-registered pass-through would be caught.
    sample_valid = 1'b0; sample_last = 1'b0; sample_in = ~si; sample_expected = ~se;
    for (int c = 1; c <= SETTLE; c++) begin
      check("fwd_layer_valid", layer_valid, 1);
      check("fwd_layer_learn", layer_learn, 0);
      check("fwd_layer_in", layer_in, si);
      check("fwd_layer_expected", layer_expected_out, se);
      check("fwd_result_valid", result_valid, 0);
      if (c < SETTLE) step();
    end
    step();
    err = model_err(lo, se);
    check("cap_result_valid", result_valid, 1);
    check("cap_layer_valid", layer_valid, 0);
    check("cap_result_out", result_out, lo);
    check("cap_sample_err", sample_err, err);
    last_cap = cyc;
    exp_acc += err;
    if (exp_acc > (1 << ERR_W) - 1) exp_acc = (1 << ERR_W) - 1;
    if (tr_lat) begin
      step();
      check("learn_layer_valid", layer_valid, 1);
      check("learn_layer_learn", layer_learn, 1);
      check("learn_layer_in", layer_in, si);
      check("learn_epoch_err", epoch_err, exp_acc);
    end
    step();
    fin = 1'b0;
    if (last) begin
      exp_cnt++;
      if (exp_cnt == eff_ep) fin = 1'b1;
      else exp_acc = 0;
    end
    check("dec_done", done, fin);
    check("dec_epoch_count", epoch_count, exp_cnt);
    check("dec_epoch_err", epoch_err, exp_acc);
    check("dec_sample_ready", sample_ready, !fin);
    check("dec_result_valid", result_valid, 0);
    check("dec_layer_learn", layer_learn, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M*ZW-1:0] lo, se;
    logic [N*ZW-1:0] si;
    int caps[3];
    int rv0, ln0;

    // Reset values
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_sample_ready", sample_ready, 0);
    check("rst_layer_valid", layer_valid, 0);
    check("rst_layer_learn", layer_learn, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_done", done, 0);
    check("rst_epoch_count", epoch_count, 0);
    check("rst_epoch_err", epoch_err, 0);
    check("rst_sample_err", sample_err, 0);
    check("rst_result_out", result_out, 0);
    check("rst_layer_in", layer_in, 0);
    check("rst_layer_expected", layer_expected_out, 0);
    reset = 1'b0;
    step();
    check("idle_busy", busy, 0);

    // Infer, one epoch, three back-to-back samples
    ln0 = learn_count;
    do_start(1'b0, 8'd1);
    for (int s = 0; s < 3; s++) begin
      do_sample(s == 2, rand_n(), rand_m(), (s == 2) ? fill_m(s + 7) : rand_m());
      caps[s] = last_cap;
    end
    check("infer_spacing_1", caps[1] - caps[0], SETTLE + 2);
    check("infer_spacing_2", caps[2] - caps[1], SETTLE + 2);
    check("infer_no_learn", learn_count - ln0, 0);
    step();
    check("infer_idle_busy", busy, 0);
    check("infer_idle_done", done, 0);
    check("infer_hold_count", epoch_count, 1);
    check("infer_hold_result", result_out, fill_m(9));

    // Train, two epochs; fixed 200 vs 50 gives 5400 per sample
    ln0 = learn_count;
    do_start(1'b1, 8'd2);
    lo = fill_m(200); se = fill_m(50);
    do_sample(1'b0, rand_n(), se, lo);
    check("err_5400", sample_err, 5400);
    do_sample(1'b1, rand_n(), se, lo);
    check("epoch2_cleared", epoch_err, 0);
    si = rand_n();
    do_sample(1'b1, si, rand_m(), rand_m());
    check("train_learn_pulses", learn_count - ln0, 3);
    step();
    check("train_idle_count", epoch_count, 2);
    check("train_hold_layer_in", layer_in, si);

    // epochs_cfg = 0 behaves as one epoch
    do_start(1'b0, 8'd0);
    do_sample(1'b0, rand_n(), rand_m(), rand_m());
    do_sample(1'b1, rand_n(), rand_m(), rand_m());
    step();
    check("ep0_idle_busy", busy, 0);
    check("ep0_count", epoch_count, 1);

    // Source stall in FETCH with a start pulse while busy
    do_start(1'b0, 8'd1);
    rv0 = rv_count;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin start = 1'b1; train = 1'b1; epochs_cfg = 8'd5; end
      if (i == 2) start = 1'b0;
      step();
      check("stall_ready", sample_ready, 1);
      check("stall_layer_valid", layer_valid, 0);
      check("stall_busy", busy, 1);
      check("stall_no_result", rv_count - rv0, 0);
    end
    do_sample(1'b1, rand_n(), rand_m(), rand_m());
    check("stall_one_result", rv_count - rv0, 1);
    step();

    // Reset during FWD
    do_start(1'b1, 8'd3);
    sample_valid = 1'b1; sample_in = rand_n(); sample_expected = rand_m(); sample_last = 1'b0;
    step();
    sample_valid = 1'b0;
    check("rfwd_layer_valid_pre", layer_valid, 1);
    reset = 1'b1;
    step();
    check("rfwd_busy", busy, 0);
    check("rfwd_layer_valid", layer_valid, 0);
    check("rfwd_epoch_count", epoch_count, 0);
    check("rfwd_layer_in", layer_in, 0);
    check("rfwd_result_out", result_out, 0);
    check("rfwd_sample_ready", sample_ready, 0);
    reset = 1'b0;
    step();
    check("rfwd_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
